ntt_ctrl: RTL
=============

NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4, cycles from butterfly issue to its write-back (memory read plus butterfly); legal range 1..8.
REQ-002 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to run a transform, sampled only in IDLE.
REQ-005 SHALL have port mode  input  ntt_mode_e  NTT_FWD or NTT_INV, captured with start.
REQ-006 SHALL have port stall  input  1  freezes issue, counters and the write-back delay line while high.
REQ-007 SHALL have port busy  output  1  high from the cycle after accepted start through the done cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the transform completes.
REQ-009 SHALL have ports rd_en  output  1, rd_addr_a / rd_addr_b  output  8  butterfly operand read request and addresses.
REQ-010 SHALL have port zeta_idx  output  7  twiddle ROM index, valid with rd_en.
REQ-011 SHALL have ports wr_en  output  1, wr_addr_a / wr_addr_b  output  8  write-back strobe and addresses.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE.
IDLE->RUN on start; RUN->DRAIN after the 128th issue of a layer; DRAIN->RUN after PIPE_LAT unstalled cycles if layers remain, else DRAIN->DONE; DONE->IDLE unconditionally.
REQ-013 SHALL issue exactly one butterfly per unstalled RUN cycle (rd_en=1), with layer l in 0..6 and butterfly index b in 0..127.
REQ-014 Forward: len = 128>>l, group = b/len, off = b%len, rd_addr_a = 2*len*group + off, rd_addr_b = rd_addr_a + len, zeta_idx = 2^l + group.
REQ-015 Inverse: len = 2<<l, G = 128/len, same address rule, zeta_idx = 2*G - 1 - group.
REQ-016 SHALL present wr_en, wr_addr_a and wr_addr_b exactly PIPE_LAT unstalled cycles after the matching issue, with identical addresses.
REQ-017 SHALL hold rd_en=0 during DRAIN so that no next-layer read precedes the final write of the current layer.
REQ-018 Without stall, SHALL issue the first butterfly in the cycle after start, with layer k starting at cycle 1 + k*(128+PIPE_LAT).
The last wr_en SHALL occur at cycle 924 and done=1 at cycle 925 (PIPE_LAT=4).
REQ-019 SHALL ignore start while busy, and SHALL ignore mode changes after capture.
REQ-020 While stall=1, SHALL force rd_en=0 and wr_en=0 and hold all counters, the state and the delay-line contents; resuming SHALL continue with no lost or duplicated butterfly.
REQ-021 SHALL have done and busy both high in the DONE cycle, with busy=0 the following cycle; a start in that following cycle SHALL be accepted.
REQ-022 SHALL perform no arithmetic on coefficients; all counters SHALL be unsigned, with no wrap beyond 0..127 (b) or 0..6 (layer).

Reset
REQ-023 rst SHALL move the state to IDLE within one edge from any state, including mid-RUN or mid-DRAIN.
REQ-024 rst SHALL clear busy, done, rd_en, wr_en, all addresses, zeta_idx, the counters and every delay-line valid bit to 0.
No write-back of an aborted transform SHALL appear after reset.

Structure
REQ-025 SHALL place the following in ntt_pkg: NTT_LAYERS=7, NTT_BFLY_PER_LAYER=128, NTT_ADDR_WIDTH=8, ZETA_IDX_WIDTH=7, typedef enum ntt_mode_e {NTT_FWD, NTT_INV}, and typedef enum ntt_ctrl_state_e.
REQ-026 SHALL instantiate one combinational sub-module, ntt_addr_gen (inputs: mode, layer, b; outputs: addr_a, addr_b, zeta_idx).
The delay line SHALL remain inside ntt_ctrl.

Verification
REQ-027 Forward, PIPE_LAT=4, no stall -> first issue a=0, b=128, zeta=1; first issue of layer 6 a=0, b=2, zeta=64; last issue a=253, b=255, zeta=127; done at cycle 925; 896 wr_en total.
REQ-028 Inverse -> first issue a=0, b=2, zeta=127; first issue of layer 6 a=0, b=128, zeta=1; every address pair appears once per layer.
REQ-029 Stall high for 10 cycles at butterfly 60 of layer 2, and again during DRAIN -> issue/write sequence identical to the unstalled run; done delayed by exactly the stalled cycle count.
REQ-030 rst asserted at cycle 300 -> all outputs 0 next cycle and no wr_en thereafter; a new start runs a full 925-cycle transform.
REQ-031 Start pulsed while busy, and mode toggled mid-run -> no effect; start in the cycle after done -> accepted.
REQ-032 Scoreboard over all runs -> no rd_en of layer l+1 before the last wr_en of layer l; each wr_addr equals its issue address delayed by PIPE_LAT.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT butterfly sequencer.
package ntt_pkg;

    localparam int NTT_LAYERS         = 7;
    localparam int NTT_BFLY_PER_LAYER = 128;
    localparam int NTT_ADDR_WIDTH     = 8;
    localparam int ZETA_IDX_WIDTH     = 7;
    localparam int LAYER_WIDTH        = 3;
    localparam int BFLY_WIDTH         = 7;

    typedef enum logic {
        NTT_FWD = 1'b0,
        NTT_INV = 1'b1
    } ntt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_ctrl_state_e;

    typedef struct packed {
        logic                      valid;
        logic [NTT_ADDR_WIDTH-1:0] addr_a;
        logic [NTT_ADDR_WIDTH-1:0] addr_b;
    } ntt_wb_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly operand address and twiddle index generator.
// The butterfly span is always a power of two, so divide/modulo reduce to shifts and masks.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  ntt_mode_e                  mode,
    input  logic [LAYER_WIDTH-1:0]     layer,
    input  logic [BFLY_WIDTH-1:0]      b,
    output logic [NTT_ADDR_WIDTH-1:0]  addr_a,
    output logic [NTT_ADDR_WIDTH-1:0]  addr_b,
    output logic [ZETA_IDX_WIDTH-1:0]  zeta_idx
);

    logic [3:0]                shift;
    logic [NTT_ADDR_WIDTH-1:0] span;
    logic [BFLY_WIDTH-1:0]     group;
    logic [BFLY_WIDTH-1:0]     offset;

    always_comb begin
        shift = '0;
        if (mode == NTT_FWD) begin
            shift = 4'd7 - {1'b0, layer};
        end else begin
            shift = {1'b0, layer} + 4'd1;
        end

        span   = 8'd1 << shift;
        group  = b >> shift;
        // span of 128 leaves span[6:0] at zero, so the mask wraps to all ones
        offset = b & (span[6:0] - 7'd1);

        addr_a = ({1'b0, group} << (shift + 4'd1)) | {1'b0, offset};
        addr_b = addr_a + span;

        if (mode == NTT_FWD) begin
            zeta_idx = (7'd1 << layer) + group;
        end else begin
            zeta_idx = (7'h7F >> layer) - group;
        end
    end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT layer/butterfly sequencer: issues operand reads and replays their addresses
// as write-backs PIPE_LAT unstalled cycles later through an internal delay line.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int PIPE_LAT = 4
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  ntt_mode_e                 mode,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [NTT_ADDR_WIDTH-1:0] rd_addr_a,
    output logic [NTT_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [ZETA_IDX_WIDTH-1:0] zeta_idx,
    output logic                      wr_en,
    output logic [NTT_ADDR_WIDTH-1:0] wr_addr_a,
    output logic [NTT_ADDR_WIDTH-1:0] wr_addr_b
);

    localparam logic [3:0]             DRAIN_LAST = 4'(PIPE_LAT - 1);
    localparam logic [LAYER_WIDTH-1:0] LAST_LAYER = LAYER_WIDTH'(NTT_LAYERS - 1);
    localparam logic [BFLY_WIDTH-1:0]  LAST_BFLY  = BFLY_WIDTH'(NTT_BFLY_PER_LAYER - 1);

    ntt_ctrl_state_e          state_q, state_d;
    ntt_mode_e                mode_q, mode_d;
    logic [LAYER_WIDTH-1:0]   layer_q, layer_d;
    logic [BFLY_WIDTH-1:0]    b_q, b_d;
    logic [3:0]               drain_q, drain_d;
    ntt_wb_t                  wb_q [PIPE_LAT];
    ntt_wb_t                  wb_in;

    logic                      issue;
    logic [NTT_ADDR_WIDTH-1:0] gen_a;
    logic [NTT_ADDR_WIDTH-1:0] gen_b;
    logic [ZETA_IDX_WIDTH-1:0] gen_zeta;

    ntt_addr_gen u_addr_gen (
        .mode     (mode_q),
        .layer    (layer_q),
        .b        (b_q),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .zeta_idx (gen_zeta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= NTT_FWD;
            layer_q <= '0;
            b_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            layer_q <= layer_d;
            b_q     <= b_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        layer_d = layer_q;
        b_d     = b_q;
        drain_d = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    layer_d = '0;
                    b_d     = '0;
                    drain_d = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (b_q == LAST_BFLY) begin
                        b_d     = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        b_d = b_q + 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Holding reads here until the last write of the layer lands avoids a read-after-write hazard
                if (!stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        drain_d = '0;
                        if (layer_q == LAST_LAYER) begin
                            state_d = ST_DONE;
                        end else begin
                            layer_d = layer_q + 3'd1;
                            state_d = ST_RUN;
                        end
                    end else begin
                        drain_d = drain_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                layer_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign issue = (state_q == ST_RUN) && !stall;
    assign wb_in = '{valid: issue, addr_a: gen_a, addr_b: gen_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                wb_q[i] <= '0;
            end
        end else if (!stall) begin
            wb_q[0] <= wb_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wb_q[i] <= wb_q[i-1];
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_en     = issue;
    assign rd_addr_a = issue ? gen_a : '0;
    assign rd_addr_b = issue ? gen_b : '0;
    assign zeta_idx  = issue ? gen_zeta : '0;
    assign wr_en     = wb_q[PIPE_LAT-1].valid && !stall;
    assign wr_addr_a = wr_en ? wb_q[PIPE_LAT-1].addr_a : '0;
    assign wr_addr_b = wr_en ? wb_q[PIPE_LAT-1].addr_b : '0;

endmodule
